// File: rtl/sqwave_monitor.sv
// sqwave_monitor
//   Measures the high and low phase durations of an asynchronous square wave
//   (typically a divided clock), compares each complete period against the
//   expected durations, and tracks lock and error statistics.
//
// Ports
//   clock       system clock, all state updates on its rising edge
//   reset       synchronous active-low reset
//   enable      1 = monitor runs, 0 = return to IDLE (aborts the current period)
//   wave_in     square wave under test, asynchronous to clock
//   exp_high    expected high duration in clock cycles
//   exp_low     expected low duration in clock cycles
//   high_count  last measured high duration
//   low_count   last measured low duration
//   meas_valid  one-cycle pulse: a new complete period measurement is available
//   period_err  one-cycle pulse with meas_valid when either duration mismatches
//   stuck       one-cycle pulse when the phase counter saturates without an edge
//   lock        level: LOCK_N consecutive error-free periods have been seen
//   err_count   saturating count of period_err and stuck events
module sqwave_monitor #(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned LOCK_N = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             wave_in,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] exp_low,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] low_count,
  output logic             meas_valid,
  output logic             period_err,
  output logic             stuck,
  output logic             lock,
  output logic [7:0]       err_count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_N + 1);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_N);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACQ,
    S_HIGH,
    S_LOW
  } state_e;

  state_e             state_q, state_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               s3_q, s3_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [CNT_W-1:0]   low_q, low_d;
  logic               mv_q, mv_d;
  logic               perr_q, perr_d;
  logic               stuck_q, stuck_d;
  logic               lock_q, lock_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [7:0]         errc_q, errc_d;

  logic rise;
  logic fall;
  logic cnt_sat;

  always_comb begin
    // Edge detection works on the synchronized copies only.
    rise    = s2_q & ~s3_q;
    fall    = ~s2_q & s3_q;
    cnt_sat = (cnt_q == '1);

    s1_d    = wave_in;
    s2_d    = s1_q;
    s3_d    = s2_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    high_d  = high_q;
    low_d   = low_q;
    mv_d    = 1'b0;
    perr_d  = 1'b0;
    stuck_d = 1'b0;
    match_d = match_q;
    errc_d  = errc_q;
    // lock follows the match counter one cycle later, so an error drops it on
    // the cycle after the period_err/stuck pulse.
    lock_d  = (match_q == MATCH_FULL);

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      match_d = '0;
      lock_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ACQ;
          cnt_d   = '0;
        end
        S_ACQ: begin
          if (rise) begin
            state_d = S_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        S_HIGH: begin
          if (fall) begin
            high_d  = cnt_q;
            state_d = S_LOW;
            cnt_d   = CNT_ONE;
          end else if (cnt_sat) begin
            stuck_d = 1'b1;
            state_d = S_ACQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_LOW: begin
          if (rise) begin
            low_d   = cnt_q;
            mv_d    = 1'b1;
            perr_d  = (high_q != exp_high) || (cnt_q != exp_low);
            state_d = S_HIGH;
            cnt_d   = CNT_ONE;
          end else if (cnt_sat) begin
            stuck_d = 1'b1;
            state_d = S_ACQ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // period_err and stuck can never coincide: they come from exclusive branches.
    if (perr_d || stuck_d) begin
      match_d = '0;
      if (errc_q != 8'hFF) begin
        errc_d = errc_q + 8'd1;
      end
    end else if (mv_d && (match_q != MATCH_FULL)) begin
      match_d = match_q + MATCH_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      cnt_q   <= '0;
      high_q  <= '0;
      low_q   <= '0;
      mv_q    <= 1'b0;
      perr_q  <= 1'b0;
      stuck_q <= 1'b0;
      lock_q  <= 1'b0;
      match_q <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
      mv_q    <= mv_d;
      perr_q  <= perr_d;
      stuck_q <= stuck_d;
      lock_q  <= lock_d;
      match_q <= match_d;
      errc_q  <= errc_d;
    end
  end

  assign high_count = high_q;
  assign low_count  = low_q;
  assign meas_valid = mv_q;
  assign period_err = perr_q;
  assign stuck      = stuck_q;
  assign lock       = lock_q;
  assign err_count  = errc_q;

endmodule

// File: tb/tb_sqwave_monitor.sv
// tb_sqwave_monitor
//   Randomized scoreboard bench for sqwave_monitor. The stimulus process
//   builds the wave as a sequence of (high, low) phases and predicts each
//   period measurement / stuck event from those phase lengths; a monitor
//   process pops and compares whenever the DUT pulses meas_valid or stuck.
module tb_sqwave_monitor;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LOCK_N = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             wave_in;
  logic [CNT_W-1:0] exp_high;
  logic [CNT_W-1:0] exp_low;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] low_count;
  logic             meas_valid;
  logic             period_err;
  logic             stuck;
  logic             lock;
  logic [7:0]       err_count;

  always #5 clock = ~clock;

  sqwave_monitor #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .wave_in    (wave_in),
    .exp_high   (exp_high),
    .exp_low    (exp_low),
    .high_count (high_count),
    .low_count  (low_count),
    .meas_valid (meas_valid),
    .period_err (period_err),
    .stuck      (stuck),
    .lock       (lock),
    .err_count  (err_count)
  );

  typedef struct {
    bit is_stuck;
    int hc;
    int lc;
    bit perr;
    int errc;
    bit lk;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (phase lengths, not RTL state)
  int m_eh, m_el;
  int m_match, m_errc, m_hc, m_lc;
  bit m_have;
  int m_ph, m_pl;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) begin
      wave_in = v;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bump_err();
    if (m_errc < 255) m_errc++;
  endtask

  // Predict the measurement of the previous full period, completed by the rise
  // about to be driven.
  task automatic push_meas();
    exp_t e;
    bit   err;
    err = (m_ph != m_eh) || (m_pl != m_el);
    if (err) begin
      m_match = 0;
      bump_err();
    end else if (m_match < LOCK_N) begin
      m_match++;
    end
    m_hc       = m_ph;
    m_lc       = m_pl;
    e.is_stuck = 1'b0;
    e.hc       = m_hc;
    e.lc       = m_lc;
    e.perr     = err;
    e.errc     = m_errc;
    e.lk       = (m_match == LOCK_N);
    sb.push_back(e);
  endtask

  task automatic push_stuck();
    exp_t e;
    m_match = 0;
    bump_err();
    e.is_stuck = 1'b1;
    e.hc       = m_hc;
    e.lc       = m_lc;
    e.perr     = 1'b0;
    e.errc     = m_errc;
    e.lk       = 1'b0;
    sb.push_back(e);
  endtask

  task automatic period(input int h, input int l);
    if (m_have) push_meas();
    hold(1'b1, h);
    m_hc = h;
    hold(1'b0, l);
    m_ph   = h;
    m_pl   = l;
    m_have = 1'b1;
  endtask

  // Extend the current low phase past saturation.
  task automatic stuck_low();
    push_stuck();
    m_have = 1'b0;
    hold(1'b0, 20);
  endtask

  task automatic stuck_high();
    if (m_have) push_meas();
    push_stuck();
    m_have = 1'b0;
    hold(1'b1, 20);
    hold(1'b0, 4);
  endtask

  task automatic start_segment(input int eh, input int el);
    exp_high = CNT_W'(eh);
    exp_low  = CNT_W'(el);
    m_eh     = eh;
    m_el     = el;
    hold(1'b0, 4);
  endtask

  // Complete the pending period, then drop enable in the middle of LOW.
  task automatic end_disable();
    int h;
    if (m_have) push_meas();
    h = $urandom_range(8, 2);
    hold(1'b1, h);
    m_hc = h;
    hold(1'b0, 3);
    enable = 1'b0;
    hold(1'b0, 3);
    check("lock_while_disabled", lock, 0);
    check("meas_valid_while_disabled", meas_valid, 0);
    enable  = 1'b1;
    m_match = 0;
    m_have  = 1'b0;
  endtask

  // Complete the pending period, then pulse reset in the middle of HIGH.
  task automatic end_reset();
    if (m_have) push_meas();
    hold(1'b1, 6);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("rst_high_count", high_count, 0);
    check("rst_low_count", low_count, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_period_err", period_err, 0);
    check("rst_stuck", stuck, 0);
    check("rst_lock", lock, 0);
    check("rst_err_count", err_count, 0);
    reset   = 1'b1;
    m_errc  = 0;
    m_hc    = 0;
    m_lc    = 0;
    m_match = 0;
    m_have  = 1'b0;
  endtask

  // Monitor: compares every meas_valid/stuck pulse with the scoreboard head
  initial begin : monitor
    exp_t e;
    bit   pend;
    int   plk;
    pend = 1'b0;
    plk  = 0;
    forever begin
      @(negedge clock);
      if (pend) begin
        check("lock_after_event", lock, plk);
        pend = 1'b0;
      end
      if (meas_valid || stuck) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: meas_valid=%0b stuck=%0b required none at %0t",
                   meas_valid, stuck, $time);
        end else begin
          e = sb.pop_front();
          check("stuck_flag", stuck, e.is_stuck);
          check("meas_valid_flag", meas_valid, !e.is_stuck);
          check("high_count", high_count, e.hc);
          check("low_count", low_count, e.lc);
          check("period_err", period_err, e.perr);
          check("err_count", err_count, e.errc);
          pend = 1'b1;
          plk  = e.lk;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int eh;
    int el;
    int mode;
    int waited;

    reset    = 1'b0;
    enable   = 1'b1;
    wave_in  = 1'b0;
    exp_high = CNT_W'(3);
    exp_low  = CNT_W'(3);
    m_match  = 0;
    m_errc   = 0;
    m_hc     = 0;
    m_lc     = 0;
    m_have   = 1'b0;
    m_ph     = 0;
    m_pl     = 0;
    repeat (3) @(posedge clock);
    #1;
    check("init_high_count", high_count, 0);
    check("init_low_count", low_count, 0);
    check("init_meas_valid", meas_valid, 0);
    check("init_period_err", period_err, 0);
    check("init_stuck", stuck, 0);
    check("init_lock", lock, 0);
    check("init_err_count", err_count, 0);
    reset = 1'b1;

    // Nominal 3/3 wave reaching lock, then a 4/2 period error while locked
    start_segment(3, 3);
    repeat (6) period(3, 3);
    period(4, 2);
    repeat (3) period(3, 3);
    end_disable();

    // Stuck in LOW and in HIGH
    start_segment(5, 4);
    repeat (3) period(5, 4);
    stuck_low();
    repeat (3) period(5, 4);
    stuck_high();
    repeat (2) period(5, 4);
    end_reset();

    // Randomized segments
    for (int s = 0; s < 20; s++) begin
      eh = $urandom_range(10, 1);
      el = $urandom_range(10, 1);
      start_segment(eh, el);
      n = $urandom_range(9, 3);
      for (int p = 0; p < n; p++) begin
        if (($urandom % 3) != 0) period(eh, el);
        else period($urandom_range(12, 1), $urandom_range(12, 1));
      end
      mode = $urandom % 3;
      if (mode == 0) begin
        end_disable();
      end else if (mode == 1) begin
        end_reset();
      end else begin
        stuck_low();
        repeat (3) period(eh, el);
        stuck_high();
        period(eh, el);
        end_disable();
      end
    end

    // Longest non-saturating phases, then err_count saturation
    start_segment(15, 15);
    period(15, 15);
    period(15, 15);
    repeat (300) period(1, 1);
    end_disable();

    waited = 0;
    while ((sb.size() != 0) && (waited < 50)) begin
      @(posedge clock);
      waited++;
    end
    repeat (3) @(posedge clock);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d events outstanding expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sqwave_monitor.md
SQWAVE_MONITOR -- requirements
Module: sqwave_monitor

Interface
REQ-001 Parameter: CNT_W, default 4, width of phase counters and expected-duration inputs.
REQ-002 Parameter: LOCK_N, default 4, consecutive matching periods required to assert lock.
REQ-003 Port: clock  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 Port: enable  input  1  1 = monitor runs; 0 = return to IDLE.
REQ-006 Port: wave_in  input  1  square wave under test (divided clock); treated as asynchronous.
REQ-007 Port: exp_high  input  CNT_W  expected high duration in clock cycles.
REQ-008 Port: exp_low  input  CNT_W  expected low duration in clock cycles.
REQ-009 Port: high_count  output  CNT_W  last measured high duration.
REQ-010 Port: low_count  output  CNT_W  last measured low duration.
REQ-011 Port: meas_valid  output  1  one-cycle pulse marking a new complete period measurement.
REQ-012 Port: period_err  output  1  one-cycle pulse, coincident with meas_valid, when either duration mismatches its expected value.
REQ-013 Port: stuck  output  1  one-cycle pulse when no edge occurs before the counter saturates.
REQ-014 Port: lock  output  1  level; LOCK_N consecutive error-free periods have been seen.
REQ-015 Port: err_count  output  8  saturating count of period_err and stuck events.

Function
REQ-016 wave_in shall pass through a two-flop synchronizer (s1, s2); s3 shall hold the previous s2. Rise = s2&~s3, fall = ~s2&s3.
REQ-017 The FSM shall have four states: IDLE, ACQ, HIGH, LOW.
REQ-018 IDLE: stay while enable=0; go to ACQ when enable=1.
REQ-019 ACQ: discard the partial phase; on rise, go to HIGH with run counter=1.
REQ-020 HIGH: on fall, latch high_count=counter, go to LOW, counter=1; otherwise counter+1.
REQ-021 LOW: on rise, latch low_count=counter, pulse meas_valid, go to HIGH, counter=1; otherwise counter+1.
REQ-022 The comparison at the end of a period shall use the high_count being latched that period and the exp_high/exp_low values sampled in the meas_valid cycle; period_err=1 if either differs.
REQ-023 Counter saturation: if counter equals 2^CNT_W-1 in HIGH or LOW with no edge that cycle, the block shall pulse stuck, go to ACQ, and hold high_count/low_count unchanged.
REQ-024 Lock: a matching-period counter shall increment on each meas_valid without period_err and saturate at LOCK_N; lock=1 while it equals LOCK_N; period_err or stuck shall clear it to 0 and deassert lock on the following cycle.
REQ-025 err_count shall increment by 1 per period_err or stuck pulse (never both in one cycle) and saturate at 255.
REQ-026 Latency: counting the edge that first samples wave_in high as edge 1, meas_valid shall be visible after edge 3.
REQ-027 enable=0 in any state shall go to IDLE next cycle, abort the in-progress period without a pulse, and clear lock; counts and err_count shall be retained.
REQ-028 Outputs shall be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 With reset=0 at a clock edge: state=IDLE, synchronizer flops=0, counter=0, high_count=0, low_count=0, meas_valid=0, period_err=0, stuck=0, lock=0, err_count=0.
REQ-030 Reset asserted mid-period shall abandon the measurement; the first period after release shall begin from ACQ.

Verification
REQ-031 exp 3/3, wave_in high 3/low 3 cycles, enable=1 -> meas_valid every 6 cycles, high_count=3, low_count=3, period_err=0, lock=1 after the 4th meas_valid.
REQ-032 exp 3/3, wave 4 high/2 low, locked beforehand -> period_err with meas_valid, high_count=4, low_count=2, lock drops next cycle, err_count+1.
REQ-033 wave_in held 0 for 20 cycles while in LOW -> stuck pulses once at counter=15, state ACQ, err_count+1, counts unchanged.
REQ-034 reset=0 for one edge mid-HIGH -> all outputs 0 next cycle; after release, the first meas_valid appears one full period after the first rise.
REQ-035 enable dropped mid-LOW then re-raised -> no meas_valid for the aborted period, lock=0, next valid period measured correctly.
REQ-036 Period-error and stuck events beyond 255 -> err_count holds at 255.
